// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file with busy scoreboard.
// Optional feature macro used by this codebase slice: RF_BYPASS_EN (write-first reads).
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_MAX  = 4;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]         xword_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set when an instruction issues with that
// destination, cleared when its result is written back. Entry 0 is never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    output logic [NREG-1:0] busy_q,
    output logic [NREG-1:0] busy_nxt,
    output logic            busy_any
);

    // Next-state busy vector; a new producer wins over a retiring one.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
        busy_nxt = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (iss_valid && (iss_rd == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (we && (wa == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy state register; cleared asynchronously so pending producers are forgotten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Any-busy summary straight from the state flops (not an extra register stage).
    assign busy_any = |busy_q;

endmodule : rf_scoreboard

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with one write port and a busy
// scoreboard. Entry 0 reads as zero and ignores writes. Read ports have a
// one-cycle registered output and hold their value while not enabled.
// Macro RF_BYPASS_EN: when defined, a same-cycle write (and scoreboard
// update) is forwarded to the read ports (write-first); otherwise reads see
// the pre-edge contents (read-first) and decode must stall on a collision.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [XLEN-1:0]   wd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              busy_any
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .wa        (wa),
        .busy_q    (busy_q),
        .busy_nxt  (busy_nxt),
        .busy_any  (busy_any)
    );

    // Storage array: writes to entry 0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset on purpose -- architectural state must read as zero after reset.
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem_q[wa] <= wd;
        end
    end

`ifndef RF_BYPASS_EN
    // Read-first build has no use for the forwarded busy state.
    logic busy_nxt_unused;
    assign busy_nxt_unused = ^busy_nxt;
`endif

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;
        logic            bval;
        logic [XLEN-1:0] rd_d;
        logic [XLEN-1:0] rd_q;
        logic            rd_busy_d;
        logic            rd_busy_q;

        assign addr = ra[i*AW +: AW];

`ifdef RF_BYPASS_EN
        // Write-first: forward this cycle's write data and next-state busy.
        assign val  = (addr == '0) ? '0 :
                      (we && (wa == addr)) ? wd : mem_q[addr];
        assign bval = busy_nxt[addr];
`else
        // Read-first: the port sees contents from before this edge.
        assign val  = (addr == '0) ? '0 : mem_q[addr];
        assign bval = busy_q[addr];
`endif

        // Port next-state: capture on enable, otherwise hold.
        always_comb begin
            rd_d      = rd_q;
            rd_busy_d = rd_busy_q;
            if (re[i]) begin
                rd_d      = val;
                rd_busy_d = bval;
            end
        end

        // Registered port outputs, cleared asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q      <= '0;
                rd_busy_q <= 1'b0;
            end else begin
                rd_q      <= rd_d;
                rd_busy_q <= rd_busy_d;
            end
        end

        assign rd[i*XLEN +: XLEN] = rd_q;
        assign rd_busy[i]         = rd_busy_q;
    end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (XLEN=32, NREG=32, NRD=2).
// Expected values are built per build flavour (RF_BYPASS_EN defined or not).
module tb_regfile_mp_sb;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  re;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic        we;
    reg_addr_t   wa;
    xword_t      wd;
    logic        iss_valid;
    reg_addr_t   iss_rd;
    logic        busy_any;

    regfile_mp_sb #(
        .XLEN (32),
        .NREG (32),
        .NRD  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_any  (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      we;
        reg_addr_t wa;
        xword_t    wd;
        logic      iv;
        reg_addr_t ird;
        logic [1:0] re;
        reg_addr_t ra0;
        reg_addr_t ra1;
        xword_t    e0;
        xword_t    e1;
        logic [1:0] eb;
        logic      ea;
    } vec_t;

    typedef struct {
        xword_t     e0;
        xword_t     e1;
        logic [1:0] eb;
        logic       ea;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic w, reg_addr_t a, xword_t d, logic iv, reg_addr_t ird,
                                logic [1:0] r, reg_addr_t a0, reg_addr_t a1,
                                xword_t e0, xword_t e1, logic [1:0] eb, logic ea);
        vec_t v;
        v.we = w; v.wa = a; v.wd = d; v.iv = iv; v.ird = ird;
        v.re = r; v.ra0 = a0; v.ra1 = a1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic drive(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        we = v.we; wa = v.wa; wd = v.wd;
        iss_valid = v.iv; iss_rd = v.ird;
        re = v.re; ra = {v.ra1, v.ra0};
        e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.ea = v.ea; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, " rd0"}, {32'd0, rd[31:0]}, {32'd0, e.e0});
            check({e.tag, " rd1"}, {32'd0, rd[63:32]}, {32'd0, e.e1});
            check({e.tag, " rd_busy"}, {62'd0, rd_busy}, {62'd0, e.eb});
            check({e.tag, " busy_any"}, {63'd0, busy_any}, {63'd0, e.ea});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; re = '0; ra = '0; we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rd", rd, 64'd0);
        check("reset rd_busy", {62'd0, rd_busy}, 64'd0);
        check("reset busy_any", {63'd0, busy_any}, 64'd0);
        rst_n = 1'b1;

        // Every register on every port reads zero after reset.
        for (int r = 0; r < 32; r++) begin
            drive(mk(0, 0, 0, 0, 0, 2'b11, reg_addr_t'(r), reg_addr_t'(31 - r), 0, 0, 2'b00, 0),
                  $sformatf("reset_read r%0d", r));
        end

        //        we wa  wd            iv ird re     ra0 ra1 e0                         e1            eb                  ea
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 0,                        0,            2'b00,              0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 2'b01, 5, 0, 32'hDEADBEEF,             0,            2'b00,              0));
        tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 2'b00, 0, 0, 32'hDEADBEEF,             0,            2'b00,              0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 2'b11, 0, 5, 0,                        32'hDEADBEEF, 2'b00,              0));
        tbl.push_back(mk(1, 9, 4,            0, 0, 2'b00, 0, 0, 0,                        32'hDEADBEEF, 2'b00,              0));
        tbl.push_back(mk(1, 9, 32'hA5A5A5A5, 0, 0, 2'b01, 9, 0, BYP ? 32'hA5A5A5A5 : 32'd4, 32'hDEADBEEF, 2'b00,              0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 2'b01, 9, 0, 32'hA5A5A5A5,             32'hDEADBEEF, 2'b00,              0));
        tbl.push_back(mk(0, 0, 0,            1, 7, 2'b00, 0, 0, 32'hA5A5A5A5,             32'hDEADBEEF, 2'b00,              1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 2'b01, 7, 0, 0,                        32'hDEADBEEF, 2'b01,              1));
        tbl.push_back(mk(1, 7, 32'h77,       0, 0, 2'b01, 7, 0, BYP ? 32'h77 : 32'd0,     32'hDEADBEEF, BYP ? 2'b00 : 2'b01, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 2'b01, 7, 0, 32'h77,                   32'hDEADBEEF, 2'b00,              0));
        tbl.push_back(mk(1, 7, 32'h88,       1, 7, 2'b00, 0, 0, 32'h77,                   32'hDEADBEEF, 2'b00,              1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 2'b01, 7, 0, 32'h88,                   32'hDEADBEEF, 2'b01,              1));
        tbl.push_back(mk(1, 7, 32'h99,       0, 0, 2'b00, 0, 0, 32'h88,                   32'hDEADBEEF, 2'b01,              0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 2'b01, 0, 0, 0,                        32'hDEADBEEF, 2'b00,              0));
        tbl.push_back(mk(0, 0, 0,            1, 3, 2'b11, 3, 3, 0,                        0,            BYP ? 2'b11 : 2'b00, 1));
        tbl.push_back(mk(1, 3, 32'h33,       0, 0, 2'b00, 0, 0, 0,                        0,            BYP ? 2'b11 : 2'b00, 0));

        foreach (tbl[k]) drive(tbl[k], $sformatf("vec%0d", k));

        // Hold: ports keep old data while r3 changes underneath.
        drive(mk(0, 0, 0, 0, 0, 2'b11, 3, 3, 32'h33, 32'h33, 2'b00, 0), "hold_load");
        for (int k = 1; k <= 3; k++) begin
            drive(mk(1, 3, xword_t'(32'h100 + k), 0, 0, 2'b00, 0, 0, 32'h33, 32'h33, 2'b00, 0),
                  $sformatf("hold%0d", k));
        end
        drive(mk(0, 0, 0, 0, 0, 2'b11, 3, 5, 32'h103, 32'hDEADBEEF, 2'b00, 0), "hold_release");

        // Reset mid-operation: busy r1..r4, r2=0x55, then an async pulse between edges.
        drive(mk(1, 2, 32'h55, 1, 1, 2'b00, 0, 0, 32'h103, 32'hDEADBEEF, 2'b00, 1), "mid_iss1");
        for (int k = 2; k <= 4; k++) begin
            drive(mk(0, 0, 0, 1, reg_addr_t'(k), 2'b00, 0, 0, 32'h103, 32'hDEADBEEF, 2'b00, 1),
                  $sformatf("mid_iss%0d", k));
        end
        drive(mk(0, 0, 0, 0, 0, 2'b11, 2, 4, 32'h55, 0, 2'b11, 1), "mid_read");
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset rd", rd, 64'd0);
        check("async_reset rd_busy", {62'd0, rd_busy}, 64'd0);
        check("async_reset busy_any", {63'd0, busy_any}, 64'd0);
        #1;
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 2'b11, 2, 1, 0, 0, 2'b00, 0), "post_reset_read");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_mp_sb
